// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer for a shared single-port RAM.
// One RAM access per grant; read data is returned to the winning port after RD_LAT cycles.
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_gnt;
  logic             win_port;
  logic             win_nxt;
  logic             take;
  logic             cap;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ram_we is only high in ACCESS, so it doubles as the latched read/write flag there
  always_comb begin
    state_nxt = state;
    win_nxt   = win_port;
    take      = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (req_0 || req_1) begin
          take      = 1'b1;
          win_nxt   = (req_0 && req_1) ? ~last_gnt : req_1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: state_nxt = ram_we ? IDLE : RWAIT;
      RWAIT: begin
        if (cnt == '0) begin
          cap       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      win_port  <= 1'b0;
      cnt       <= '0;
      gnt_0     <= 1'b0;
      gnt_1     <= 1'b0;
      rvalid_0  <= 1'b0;
      rvalid_1  <= 1'b0;
      rdata_0   <= '0;
      rdata_1   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      gnt_0    <= take && !win_nxt;
      gnt_1    <= take && win_nxt;
      ram_en   <= take;
      ram_we   <= take && (win_nxt ? we_1 : we_0);
      rvalid_0 <= cap && !win_port;
      rvalid_1 <= cap && win_port;
      busy     <= (state_nxt != IDLE);
      if (take) begin
        win_port  <= win_nxt;
        last_gnt  <= win_nxt;
        ram_addr  <= win_nxt ? addr_1 : addr_0;
        ram_wdata <= win_nxt ? wdata_1 : wdata_0;
      end
      if (state == ACCESS)     cnt <= CNT_W'(RD_LAT - 1);
      else if (state == RWAIT) cnt <= cnt - CNT_W'(1);
      if (cap && !win_port) rdata_0 <= ram_rdata;
      if (cap && win_port)  rdata_1 <= ram_rdata;
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and access sequencer for the shared 64KB single-port RAM (16-bit address, 8-bit data). Two requesters, port 0 and port 1, issue read/write requests. The block picks a winner by round-robin, drives one RAM access per grant, waits out the RAM read latency, and returns read data to the winning port. It sits between the requesters and the RAM's bank-select demux tree, and is the only master driving the RAM's control inputs.

## Interface
Parameters:
- ADDR_W, 16, RAM address width (64KB).
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles, legal range 1..4. ram_rdata is valid RD_LAT cycles after the cycle in which ram_en=1 and ram_we=0.

Ports (x = 0, 1; one set of request ports per requester):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_x  in  1  request; held high with we_x/addr_x/wdata_x stable until gnt_x.
- we_x  in  1  1 = write, 0 = read.
- addr_x  in  ADDR_W  access address.
- wdata_x  in  DATA_W  write data.
- gnt_x  out  1  one-cycle grant pulse; the request is consumed.
- rvalid_x  out  1  one-cycle pulse; rdata_x is valid.
- rdata_x  out  DATA_W  read data; holds its value until the next read on that port.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, ACCESS, RWAIT.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req_x=1 at the clock edge, latch the winner's we/addr/wdata and go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration:
  - Exactly one requester: that port wins.
  - Both requesting: the port other than last_gnt wins.
  - last_gnt updates to the winner on every grant.
  - last_gnt resets to 1, so port 0 wins the first tie.
- ACCESS (exactly 1 cycle):
  - gnt_w=1, ram_en=1, ram_we=latched we, ram_addr/ram_wdata=latched values.
  - Next state is IDLE for a write, RWAIT for a read.
- RWAIT:
  - Stays for RD_LAT cycles; an internal counter is loaded with RD_LAT-1 on entry.
  - On the last cycle, ram_rdata is captured into rdata_w. Next state is IDLE.
  - rvalid_w=1 in the first IDLE cycle after RWAIT.
- The losing request stays pending; it is served in a later IDLE slot with no loss.
- Dropping req_x before gnt_x cancels the request; no RAM access occurs.
- Outside ACCESS: ram_en=0, ram_we=0. ram_addr/ram_wdata hold their last values.
- Only the winner's gnt/rvalid ever pulse; the other port's gnt/rvalid stay 0.
- Reset (asynchronous, any time):
  - state=IDLE, last_gnt=1.
  - gnt_x, rvalid_x, rdata_x, ram_en, ram_we, ram_addr, ram_wdata, busy all 0.
  - An in-flight read is discarded; no rvalid follows reset release.

## Timing
- Request sampled at the edge ending cycle t (in IDLE). gnt_w and ram_en are high in cycle t+1.
- Write: IDLE again in t+2. A new request can be sampled at the end of t+2, so the peak write rate is 1 access per 2 cycles.
- Read:
  - RWAIT covers cycles t+2 .. t+1+RD_LAT.
  - rvalid_w/rdata_w appear in cycle t+2+RD_LAT, which is an IDLE cycle and can sample a new request.
  - Request-to-data latency is RD_LAT+2 cycles; peak read rate is 1 per RD_LAT+2 cycles.
- All outputs are registered; none depends combinationally on req_x or ram_rdata.
- busy is high from t+1 through the last RWAIT cycle (read), or in t+1 only (write).

## Test plan
- Reset, then write from port 0: req_0=1, we_0=1, addr_0=16'h1234, wdata_0=8'hA5.
  - gnt_0 and ram_en high in the same single cycle, with ram_we=1, ram_addr=16'h1234, ram_wdata=8'hA5.
  - busy for exactly 1 cycle; gnt_1 stays 0.
- Read from port 1 with RD_LAT=1 against a RAM model holding 8'hA5 at 16'h1234.
  - rvalid_1=1 and rdata_1=8'hA5 exactly 3 cycles after the request is sampled.
  - rdata_1 holds 8'hA5 afterwards.
- Both ports request continuously after reset (port 0 writes, port 1 reads).
  - Grant order 0, 1, 0, 1.
  - No gnt_0 and gnt_1 in the same cycle; every access completes.
- RD_LAT=3 read.
  - ram_en high for 1 cycle; busy for 4 cycles.
  - rvalid 5 cycles after the request is sampled, carrying the correct data.
- rst_n asserted during RWAIT.
  - All outputs 0 immediately (asynchronous).
  - No rvalid after release; the next tie is granted to port 0.
- req_0 pulsed high for one cycle while state != IDLE, then dropped.
  - No gnt_0 and no extra RAM access.
